collision_score_unit: RTL and testbench
=======================================

// Module: collision_score_unit
// PURPOSE
//  Pixel-rate collision detector and game-state bookkeeper; sits upstream of the top-level RGB mux and the hud.
//  Detects laser/alien and bomb/cannon overlap during the raster scan.
//  Owns alive_matrix, score and lives, and drives hit_alien back to cannon_laser.
//  Commits all updates once per frame, at the vsync rising edge.
// PARAMETERS
//  NUM_ROWS       5    alien rows
//  NUM_COLUMNS    8    alien columns
//  CELL_W_LOG2    5    alien cell width  = 2**CELL_W_LOG2 px
//  CELL_H_LOG2    5    alien cell height = 2**CELL_H_LOG2 px
//  START_LIVES    3    lives loaded on reset/reset_game (1..3)
//  INVULN_FRAMES  60   frames a cannon hit is ignored after a life is lost
//  SCORE_MAX      9999 score saturation value
// PORTS
//  clk           in   1      25 MHz pixel clock (same clock as hvsync_generator)
//  rst_n         in   1      synchronous active-low reset
//  play          in   1      1 = game_state is playing; detection enabled
//  reset_game    in   1      level; while 1, reload all game state
//  vsync         in   1      active-high frame sync from hvsync_generator
//  display_on    in   1      visible-area qualifier
//  hpos, vpos    in   10     current pixel
//  formation_x   in   10     formation top-left x
//  formation_y   in   10     formation top-left y
//  laser_gfx     in   1      laser pixel
//  alien_pixel   in   1      alien pixel
//  bomb_gfx      in   1      alien bomb pixel
//  cannon_gfx    in   1      cannon pixel
//  alive_matrix  out  [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  alien alive flags
//  hit_alien     out  1      laser-kill request to cannon_laser
//  score         out  14     binary score to hud
//  lives         out  2      to hud / game_state_machine
//  cannon_hit    out  1      1-clk pulse, life lost
//  wave_cleared  out  1      level, all aliens dead
//  game_over     out  1      level, lives==0
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk) and reset_game=1 load the same values:
//   - alive_matrix = all 1s, score = 0, lives = START_LIVES
//   - hit_alien = 0, cannon_hit = 0, invuln counter = 0, FSM = SCAN
//  reset_game has priority over every other event.
//  frame_edge = vsync & ~vsync_q (registered).
//  Alien hit FSM:
//   - SCAN: on display_on & play & laser_gfx & alien_pixel:
//     col = (hpos - formation_x) >> CELL_W_LOG2, row = (vpos - formation_y) >> CELL_H_LOG2.
//     Subtraction is 10-bit unsigned. If col<NUM_COLUMNS, row<NUM_ROWS and the bit is alive:
//     latch row/col, set hit_alien=1, go to HIT. Otherwise ignore.
//   - HIT: further overlaps ignored (max one kill per frame). On frame_edge go to COMMIT.
//   - COMMIT (1 clk): clear alive bit; score += points(row), saturating at SCORE_MAX; go to HOLD.
//   - HOLD: on vsync falling edge, clear hit_alien and go to SCAN.
//     hit_alien is therefore stable across the vsync rising edge that cannon_laser samples.
//  Points: row 0 = 30, rows 1-2 = 20, rows >= 3 = 10.
//  Cannon hit: on display_on & play & bomb_gfx & cannon_gfx with invuln==0 and lives!=0:
//   - set pending flag (once per frame).
//   - on frame_edge: lives -= 1, cannon_hit pulses 1 clk, invuln = INVULN_FRAMES.
//   - invuln decrements on each frame_edge down to 0.
//  lives saturates at 0. game_over = (lives==0); wave_cleared = (alive_matrix==0); both combinational from regs.
//  Alien hit and cannon hit in the same frame: both commit on the same frame_edge.
//  play=0: no new detection. Pending HIT/COMMIT/HOLD still completes.
// CONFIGURATION
//  EXTRA_LIFE_EN defined: the first commit that raises score from <1000 to >=1000 adds one life (cap 3).
//   Granted once per game; re-armed by reset_game.
//  EXTRA_LIFE_EN undefined: lives only decrease. No extra state is synthesized.
// STRUCTURE
//  ci_game_pkg:
//   - row-points function
//   - SCORE_MAX, EXTRA_LIFE_SCORE = 1000
//   - typedef enum {SCAN, HIT, COMMIT, HOLD} hit_state_e
//  Sub-module cell_index (combinational pixel -> row/col/in_range), reusable by the bomb logic later.
// TESTING
//  1. Laser overlaps an alien at formation(100,50), pixel (170,120) -> row 2, col 2 cleared at next frame_edge.
//     score 0->20; hit_alien high from the hit pixel to the vsync fall.
//  2. Two overlaps with different aliens in one frame -> only the first is killed.
//     score +30 for row 0; the second alien stays alive.
//  3. Bomb hits cannon with lives=1 -> at frame_edge lives=0, cannon_hit one pulse, game_over=1.
//     A second hit within 60 frames -> no change.
//  4. reset_game=1 in the same clk as a COMMIT -> alive_matrix all 1s, score 0, lives 3, hit_alien 0.
//  5. Kill all 40 aliens -> wave_cleared=1 after the 40th commit. Score 9990 + row-0 kill -> 9999.
//  6. With EXTRA_LIFE_EN: score 990 + 20 with lives=2 -> 1010 and lives 3. Without the macro -> lives stays 2.

Source files
------------

// File: rtl/ci_game_pkg.sv
// ci_game_pkg: shared constants, state type and scoring rule for the collision/score logic.
package ci_game_pkg;

    localparam int unsigned SCORE_MAX        = 9999;
    localparam int unsigned EXTRA_LIFE_SCORE = 1000;

    typedef enum logic [1:0] {SCAN, HIT, COMMIT, HOLD} hit_state_e;

    // Points for an alien kill: top row is worth the most.
    function automatic logic [5:0] row_points(input int unsigned row);
        if (row == 0) begin
            return 6'd30;
        end else if (row <= 2) begin
            return 6'd20;
        end else begin
            return 6'd10;
        end
    endfunction

endpackage

// File: rtl/cell_index.sv
// cell_index: maps the current pixel to the alien cell under it, relative to the formation
// origin. Purely combinational so the bomb logic can reuse it.
module cell_index #(
    parameter int unsigned NUM_ROWS    = 5,
    parameter int unsigned NUM_COLUMNS = 8,
    parameter int unsigned CELL_W_LOG2 = 5,
    parameter int unsigned CELL_H_LOG2 = 5,
    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int unsigned COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1
) (
    input  logic [9:0]       hpos,
    input  logic [9:0]       vpos,
    input  logic [9:0]       formation_x,
    input  logic [9:0]       formation_y,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             in_range
);

    logic [9:0] dx;
    logic [9:0] dy;
    logic [9:0] col_full;
    logic [9:0] row_full;

    // Pixels left of / above the formation wrap to large values and fall out of range.
    always_comb begin
        dx       = hpos - formation_x;
        dy       = vpos - formation_y;
        col_full = dx >> CELL_W_LOG2;
        row_full = dy >> CELL_H_LOG2;
        in_range = (col_full < 10'(NUM_COLUMNS)) && (row_full < 10'(NUM_ROWS));
        col      = col_full[COL_W-1:0];
        row      = row_full[ROW_W-1:0];
    end

endmodule

// File: rtl/collision_score_unit.sv
// collision_score_unit: pixel-rate laser/alien and bomb/cannon collision detection plus the
// game bookkeeping (alive flags, score, lives). All updates land once per frame, at the vsync
// rising edge. Define EXTRA_LIFE_EN to grant one bonus life when the score first reaches 1000.
module collision_score_unit #(
    parameter int unsigned NUM_ROWS      = 5,
    parameter int unsigned NUM_COLUMNS   = 8,
    parameter int unsigned CELL_W_LOG2   = 5,
    parameter int unsigned CELL_H_LOG2   = 5,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned SCORE_MAX     = ci_game_pkg::SCORE_MAX
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  play,
    input  logic                                  reset_game,
    input  logic                                  vsync,
    input  logic                                  display_on,
    input  logic [9:0]                            hpos,
    input  logic [9:0]                            vpos,
    input  logic [9:0]                            formation_x,
    input  logic [9:0]                            formation_y,
    input  logic                                  laser_gfx,
    input  logic                                  alien_pixel,
    input  logic                                  bomb_gfx,
    input  logic                                  cannon_gfx,
    output logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  alive_matrix,
    output logic                                  hit_alien,
    output logic [13:0]                           score,
    output logic [1:0]                            lives,
    output logic                                  cannon_hit,
    output logic                                  wave_cleared,
    output logic                                  game_over
);
    import ci_game_pkg::*;

    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam int unsigned INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    hit_state_e       state_q;
    logic             vsync_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic             cannon_pend_q;
    logic [INV_W-1:0] invuln_q;

    logic             frame_edge;
    logic             vsync_fall;
    logic             alien_overlap;
    logic             bomb_overlap;
    logic [ROW_W-1:0] idx_row;
    logic [COL_W-1:0] idx_col;
    logic             idx_in_range;
    logic [14:0]      score_sum;
    logic [13:0]      score_next;
    logic             extra_grant;

    cell_index #(
        .NUM_ROWS    (NUM_ROWS),
        .NUM_COLUMNS (NUM_COLUMNS),
        .CELL_W_LOG2 (CELL_W_LOG2),
        .CELL_H_LOG2 (CELL_H_LOG2)
    ) u_cell_index (
        .hpos        (hpos),
        .vpos        (vpos),
        .formation_x (formation_x),
        .formation_y (formation_y),
        .row         (idx_row),
        .col         (idx_col),
        .in_range    (idx_in_range)
    );

    assign frame_edge    = vsync & ~vsync_q;
    assign vsync_fall    = ~vsync & vsync_q;
    assign alien_overlap = display_on & play & laser_gfx & alien_pixel;
    assign bomb_overlap  = display_on & play & bomb_gfx & cannon_gfx;
    assign wave_cleared  = (alive_matrix == '0);
    assign game_over     = (lives == 2'd0);

    // Score after crediting the latched kill, clipped at the saturation value.
    always_comb begin
        score_sum  = {1'b0, score} + 15'(row_points(32'(row_q)));
        score_next = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
    end

`ifdef EXTRA_LIFE_EN
    logic extra_used_q;

    assign extra_grant = (state_q == COMMIT) && !extra_used_q &&
                         (score < 14'(EXTRA_LIFE_SCORE)) && (score_next >= 14'(EXTRA_LIFE_SCORE));

    // Bonus life is granted at most once per game.
    always_ff @(posedge clk) begin
        if (!rst_n || reset_game) begin
            extra_used_q <= 1'b0;
        end else if (extra_grant) begin
            extra_used_q <= 1'b1;
        end
    end
`else
    assign extra_grant = 1'b0;
`endif

    // Registered vsync for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

    // Alien-hit FSM, cannon-hit bookkeeping and all game-state registers.
    always_ff @(posedge clk) begin
        if (!rst_n || reset_game) begin
            state_q       <= SCAN;
            alive_matrix  <= '1;
            score         <= '0;
            lives         <= 2'(START_LIVES);
            hit_alien     <= 1'b0;
            cannon_hit    <= 1'b0;
            cannon_pend_q <= 1'b0;
            invuln_q      <= '0;
            row_q         <= '0;
            col_q         <= '0;
        end else begin
            cannon_hit <= 1'b0;

            case (state_q)
                SCAN: begin
                    if (alien_overlap && idx_in_range && alive_matrix[idx_row][idx_col]) begin
                        row_q     <= idx_row;
                        col_q     <= idx_col;
                        hit_alien <= 1'b1;
                        state_q   <= HIT;
                    end
                end
                HIT: begin
                    if (frame_edge) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    alive_matrix[row_q][col_q] <= 1'b0;
                    score                      <= score_next;
                    state_q                    <= HOLD;
                end
                HOLD: begin
                    // hit_alien stays high across the vsync rise that cannon_laser samples.
                    if (vsync_fall) begin
                        hit_alien <= 1'b0;
                        state_q   <= SCAN;
                    end
                end
                default: state_q <= SCAN;
            endcase

            if (frame_edge) begin
                cannon_pend_q <= 1'b0;
                if (cannon_pend_q && (lives != 2'd0)) begin
                    lives      <= lives - 2'd1;
                    cannon_hit <= 1'b1;
                    invuln_q   <= INV_W'(INVULN_FRAMES);
                end else if (invuln_q != '0) begin
                    invuln_q <= invuln_q - INV_W'(1);
                end
            end else if (bomb_overlap && (invuln_q == '0) && (lives != 2'd0)) begin
                cannon_pend_q <= 1'b1;
            end

            if (extra_grant && (lives != 2'd3)) begin
                lives <= lives + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_collision_score_unit.sv
// Bench for collision_score_unit: frame-level reference model checked every clock, directed
// scenarios pinned with literal values, then randomized frames.
`timescale 1ns/1ps
module tb_collision_score_unit;

    localparam int NR    = 5;
    localparam int NC    = 16;
    localparam int CWL   = 5;
    localparam int CHL   = 5;
    localparam int SMAX  = 1429;
    localparam int START = 3;
    localparam int INV   = 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic play = 1'b0;
    logic reset_game = 1'b0;
    logic vsync = 1'b0;
    logic display_on = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic [9:0] formation_x = '0;
    logic [9:0] formation_y = '0;
    logic laser_gfx = 1'b0;
    logic alien_pixel = 1'b0;
    logic bomb_gfx = 1'b0;
    logic cannon_gfx = 1'b0;

    logic [NR-1:0][NC-1:0] alive_matrix;
    logic        hit_alien;
    logic [13:0] score;
    logic [1:0]  lives;
    logic        cannon_hit;
    logic        wave_cleared;
    logic        game_over;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    collision_score_unit #(
        .NUM_ROWS      (NR),
        .NUM_COLUMNS   (NC),
        .CELL_W_LOG2   (CWL),
        .CELL_H_LOG2   (CHL),
        .START_LIVES   (START),
        .INVULN_FRAMES (INV),
        .SCORE_MAX     (SMAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play         (play),
        .reset_game   (reset_game),
        .vsync        (vsync),
        .display_on   (display_on),
        .hpos         (hpos),
        .vpos         (vpos),
        .formation_x  (formation_x),
        .formation_y  (formation_y),
        .laser_gfx    (laser_gfx),
        .alien_pixel  (alien_pixel),
        .bomb_gfx     (bomb_gfx),
        .cannon_gfx   (cannon_gfx),
        .alive_matrix (alive_matrix),
        .hit_alien    (hit_alien),
        .score        (score),
        .lives        (lives),
        .cannon_hit   (cannon_hit),
        .wave_cleared (wave_cleared),
        .game_over    (game_over)
    );

    always #20 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_alive [NR][NC];
    int m_score, m_lives, m_invuln, m_kr, m_kc;
    bit m_hit, m_kill_pend, m_kill_apply, m_kill_done, m_bomb_pend, m_cannon_hit, m_bonus_used;
    bit m_vs;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int points(input int r);
        if (r == 0) return 30;
        if (r <= 2) return 20;
        return 10;
    endfunction

    function automatic logic [127:0] pack_alive();
        logic [127:0] v = '0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                v[r*NC + c] = m_alive[r][c];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                m_alive[r][c] = 1'b1;
        m_score = 0;
        m_lives = START;
        m_invuln = 0;
        m_hit = 0;
        m_kill_pend = 0;
        m_kill_apply = 0;
        m_kill_done = 0;
        m_bomb_pend = 0;
        m_bonus_used = 0;
    endtask

    // Model step on every clock, then compare all outputs just after the edge.
    initial begin
        bit rise, fall;
        int dx, dy, r, c, old;
        forever begin
            @(posedge clk);
            rise = vsync && !m_vs;
            fall = !vsync && m_vs;
            m_vs = rst_n ? vsync : 1'b0;
            m_cannon_hit = 0;
            if (!rst_n || reset_game) begin
                model_reset();
            end else begin
                // a latched kill is credited one clock after the frame edge
                if (m_kill_apply) begin
                    old = m_score;
                    m_alive[m_kr][m_kc] = 0;
                    m_score = old + points(m_kr);
                    if (m_score > SMAX) m_score = SMAX;
`ifdef EXTRA_LIFE_EN
                    if (!m_bonus_used && old < 1000 && m_score >= 1000) begin
                        m_bonus_used = 1;
                        if (m_lives < 3) m_lives++;
                    end
`endif
                    m_kill_apply = 0;
                    m_kill_done = 1;
                end
                if (rise) begin
                    if (m_kill_pend) begin
                        m_kill_apply = 1;
                        m_kill_pend = 0;
                    end
                    if (m_bomb_pend && m_lives > 0) begin
                        m_lives--;
                        m_cannon_hit = 1;
                        m_invuln = INV;
                    end else if (m_invuln > 0) begin
                        m_invuln--;
                    end
                    m_bomb_pend = 0;
                end else begin
                    if (fall && m_kill_done) begin
                        m_hit = 0;
                        m_kill_done = 0;
                    end else if (display_on && play && laser_gfx && alien_pixel && !m_hit) begin
                        dx = (int'(hpos) - int'(formation_x) + 1024) % 1024;
                        dy = (int'(vpos) - int'(formation_y) + 1024) % 1024;
                        c = dx / (1 << CWL);
                        r = dy / (1 << CHL);
                        if (c < NC && r < NR && m_alive[r][c]) begin
                            m_hit = 1;
                            m_kill_pend = 1;
                            m_kr = r;
                            m_kc = c;
                        end
                    end
                    if (display_on && play && bomb_gfx && cannon_gfx && m_invuln == 0 &&
                        m_lives > 0)
                        m_bomb_pend = 1;
                end
            end
            #1;
            check("alive_matrix", alive_matrix, pack_alive());
            check("score", score, m_score);
            check("lives", lives, m_lives);
            check("hit_alien", hit_alien, m_hit);
            check("cannon_hit", cannon_hit, m_cannon_hit);
            check("wave_cleared", wave_cleared, pack_alive() == '0);
            check("game_over", game_over, m_lives == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cannon_hit === 1'b1) pulse_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_px();
        display_on = 0;
        laser_gfx = 0;
        alien_pixel = 0;
        bomb_gfx = 0;
        cannon_gfx = 0;
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_px();
        end
    endtask

    task automatic drive_pix(input int h, input int v, input bit l, input bit a, input bit b,
                             input bit cg);
        @(negedge clk);
        display_on = 1;
        hpos = 10'(h);
        vpos = 10'(v);
        laser_gfx = l;
        alien_pixel = a;
        bomb_gfx = b;
        cannon_gfx = cg;
    endtask

    task automatic end_frame();
        drive_idle(2);
        @(negedge clk);
        vsync = 1;
        repeat (3) @(negedge clk);
        vsync = 0;
        drive_idle(3);
    endtask

    task automatic kill(input int r, input int c);
        drive_idle(1);
        drive_pix(int'(formation_x) + c*32 + 5, int'(formation_y) + r*32 + 7, 1, 1, 0, 0);
        end_frame();
    endtask

    task automatic cannon_frame();
        drive_idle(1);
        drive_pix(300, 400, 0, 0, 1, 1);
        end_frame();
    endtask

    task automatic pulse_reset_game();
        @(negedge clk);
        clear_px();
        reset_game = 1;
        @(negedge clk);
        reset_game = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int p0, h, v;
        repeat (3) @(negedge clk);
        rst_n = 1;
        play = 1;
        formation_x = 10'd100;
        formation_y = 10'd50;
        drive_idle(2);
        check("reset score", score, 14'd0);
        check("reset lives", lives, 2'd3);
        check("reset alive", alive_matrix, {(NR*NC){1'b1}});

        // pixel (170,120) with formation (100,50) lands on row 2, col 2
        drive_pix(170, 120, 1, 1, 0, 0);
        @(negedge clk);
        clear_px();
        check("t1 hit_alien raised", hit_alien, 1'b1);
        check("t1 alive before edge", alive_matrix[2][2], 1'b1);
        end_frame();
        check("t1 alive[2][2] cleared", alive_matrix[2][2], 1'b0);
        check("t1 score", score, 14'd20);
        check("t1 hit_alien dropped", hit_alien, 1'b0);

        // two overlaps in one frame: only row 0 col 0 dies
        drive_pix(110, 60, 1, 1, 0, 0);
        drive_pix(145, 60, 1, 1, 0, 0);
        end_frame();
        check("t2 score", score, 14'd50);
        check("t2 alive[0][0]", alive_matrix[0][0], 1'b0);
        check("t2 alive[0][1]", alive_matrix[0][1], 1'b1);

        // reset_game during the COMMIT clock wins
        drive_pix(231, 149, 1, 1, 0, 0);
        drive_idle(2);
        @(negedge clk);
        vsync = 1;
        @(negedge clk);
        reset_game = 1;
        @(negedge clk);
        reset_game = 0;
        @(negedge clk);
        vsync = 0;
        drive_idle(3);
        check("t4 alive", alive_matrix, {(NR*NC){1'b1}});
        check("t4 score", score, 14'd0);
        check("t4 lives", lives, 2'd3);
        check("t4 hit_alien", hit_alien, 1'b0);

        // cannon hits and invulnerability
        p0 = pulse_cnt;
        cannon_frame();
        check("t3 lives after hit", lives, 2'd2);
        check("t3 one pulse", pulse_cnt - p0, 1);
        repeat (5) end_frame();
        p0 = pulse_cnt;
        cannon_frame();
        check("t3 invuln lives", lives, 2'd2);
        check("t3 invuln no pulse", pulse_cnt - p0, 0);
        repeat (60) end_frame();
        cannon_frame();
        check("t3 lives 1", lives, 2'd1);
        repeat (61) end_frame();
        p0 = pulse_cnt;
        cannon_frame();
        check("t3 lives 0", lives, 2'd0);
        check("t3 game_over", game_over, 1'b1);
        check("t3 last pulse", pulse_cnt - p0, 1);
        repeat (3) end_frame();
        p0 = pulse_cnt;
        cannon_frame();
        check("t3 lives stay 0", lives, 2'd0);
        check("t3 no pulse at 0", pulse_cnt - p0, 0);

        pulse_reset_game();
        drive_idle(1);
        check("reset_game lives", lives, 2'd3);
        check("reset_game game_over", game_over, 1'b0);

        // bonus-life crossing, then clear the wave ending on a saturating kill
        cannon_frame();
        for (int r = 3; r < 5; r++)
            for (int c = 0; c < NC; c++)
                kill(r, c);
        for (int c = 0; c < 15; c++) kill(0, c);
        for (int c = 0; c < 11; c++) kill(1, c);
        check("t6 score 990", score, 14'd990);
        check("t6 lives 2", lives, 2'd2);
        kill(1, 11);
        check("t6 score 1010", score, 14'd1010);
`ifdef EXTRA_LIFE_EN
        check("t6 bonus lives", lives, 2'd3);
`else
        check("t6 lives unchanged", lives, 2'd2);
`endif
        for (int c = 12; c < NC; c++) kill(1, c);
        for (int c = 0; c < NC; c++) kill(2, c);
        check("t5 score 1410", score, 14'd1410);
        check("t5 not cleared", wave_cleared, 1'b0);
        kill(0, 15);
        check("t5 saturated", score, 14'(SMAX));
        check("t5 wave_cleared", wave_cleared, 1'b1);
        check("t5 alive zero", alive_matrix, '0);

        // randomized frames
        pulse_reset_game();
        for (int f = 0; f < 250; f++) begin
            formation_x = 10'($urandom_range(0, 150));
            formation_y = 10'($urandom_range(0, 120));
            play = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < int'($urandom_range(3, 12)); i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    h = $urandom_range(0, 639);
                    v = $urandom_range(0, 479);
                end else begin
                    h = int'(formation_x) + $urandom_range(0, 560);
                    v = int'(formation_y) + $urandom_range(0, 200);
                end
                drive_pix(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
                if ($urandom_range(0, 7) == 0) display_on = 0;
            end
            if ($urandom_range(0, 29) == 0) pulse_reset_game();
            end_frame();
        end

        drive_idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
